// File: rtl/spi_target_fifo.sv
// SPI target with a TX word FIFO: oversamples sclk/cs/mosi in the clk domain,
// delivers received words as one-cycle pulses and streams queued words out on miso.
module spi_target_fifo #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 8,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sclk,
  input  logic                       cs,
  input  logic                       mosi,
  output logic                       miso,
  output logic [WORD_W-1:0]          rx_data,
  output logic                       rx_valid,
  input  logic [WORD_W-1:0]          tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [$clog2(DEPTH+1)-1:0] tx_count,
  output logic                       tx_underrun,
  output logic                       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WORD_W + 1);
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WORD_W);
  localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);
  localparam logic          SCLK_IDLE = (CPOL != 0);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchronizers plus one edge-detect stage per input
  logic sclk_s1_q, sclk_s2_q, sclk_d1_q;
  logic cs_s1_q, cs_s2_q, cs_d1_q;
  logic mosi_s1_q, mosi_s2_q, mosi_d1_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s1_q <= SCLK_IDLE;
      sclk_s2_q <= SCLK_IDLE;
      sclk_d1_q <= SCLK_IDLE;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_d1_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      mosi_d1_q <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_d1_q <= sclk_s2_q;
      cs_s1_q   <= cs;
      cs_s2_q   <= cs_s1_q;
      cs_d1_q   <= cs_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      mosi_d1_q <= mosi_s2_q;
    end
  end

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;

  assign sclk_rise   = sclk_s2_q & ~sclk_d1_q;
  assign sclk_fall   = ~sclk_s2_q & sclk_d1_q;
  assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s2_q & cs_d1_q;
  assign cs_rise     = cs_s2_q & ~cs_d1_q;

  // TX FIFO storage
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]     count_q, count_d;
  logic              fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = tx_valid & ~fifo_full;

  // NOTE: FIFO storage has no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d, underrun_q, underrun_d, frame_err_q, frame_err_d;
  logic              pend_q, pend_d, armed_q, armed_d;
  logic [1:0]        warm_q, warm_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    pend_d      = pend_q;
    pop         = 1'b0;
    // A frame may only open once cs has been seen high through the synchronizer
    warm_d      = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    armed_d     = armed_q | ((warm_q == 2'd2) & cs_s2_q);

    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          if (fifo_empty) begin
            tx_sh_d    = '0;
            underrun_d = 1'b1;
          end else begin
            tx_sh_d = mem_q[rd_ptr_q];
            pop     = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0) && (bit_cnt_q != LAST_BIT);
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
          end
          bit_cnt_d = '0;
          tx_sh_d   = '0;
          pend_d    = 1'b0;
        end else if (bit_cnt_q == LAST_BIT) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          bit_cnt_d  = '0;
          // An empty boundary load is reported when the MCU starts clocking that word
          if (fifo_empty) begin
            tx_sh_d = '0;
            pend_d  = 1'b1;
          end else begin
            tx_sh_d = mem_q[rd_ptr_q];
            pop     = 1'b1;
          end
        end else begin
          if (sample_edge) begin
            rx_sh_d   = {rx_sh_q[WORD_W-2:0], mosi_d1_q};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          // Counter at 0 marks the first edge of a word: MSB is already on miso
          if (shift_edge && (bit_cnt_q != '0)) tx_sh_d = {tx_sh_q[WORD_W-2:0], 1'b0};
          if (lead_edge && pend_q) begin
            underrun_d = 1'b1;
            pend_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pend_q      <= 1'b0;
      armed_q     <= 1'b0;
      warm_q      <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      pend_q      <= pend_d;
      armed_q     <= armed_d;
      warm_q      <= warm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign miso        = (state_q == SHIFT) ? tx_sh_q[WORD_W-1] : 1'b0;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~fifo_full;
  assign tx_count    = count_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_target_fifo.sv
// Directed bench for spi_target_fifo: a mode-0 instance and a mode-3 instance,
// driven as an MCU would, with hand-computed expected words and pulse counts.
module tb_spi_target_fifo;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sclk0, cs0, sclk3, cs3, mosi;
  logic [15:0] tx_data;
  logic        tx_valid0, tx_valid3;

  logic        miso0, rx_valid0, tx_ready0, tx_underrun0, frame_err0;
  logic [15:0] rx_data0;
  logic [3:0]  tx_count0;
  logic        miso3, rx_valid3, tx_ready3, tx_underrun3, frame_err3;
  logic [15:0] rx_data3;
  logic [3:0]  tx_count3;

  int checks = 0;
  int errors = 0;
  int rxv0 = 0, und0 = 0, ferr0 = 0, rxv3 = 0, und3 = 0, ferr3 = 0;

  always #5 clk = ~clk;

  spi_target_fifo #(.WORD_W(16), .DEPTH(8), .CPOL(0), .CPHA(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk0), .cs(cs0), .mosi(mosi), .miso(miso0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_data(tx_data), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx_count(tx_count0), .tx_underrun(tx_underrun0), .frame_err(frame_err0)
  );

  spi_target_fifo #(.WORD_W(16), .DEPTH(8), .CPOL(1), .CPHA(1)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk3), .cs(cs3), .mosi(mosi), .miso(miso3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .tx_data(tx_data), .tx_valid(tx_valid3),
    .tx_ready(tx_ready3), .tx_count(tx_count3), .tx_underrun(tx_underrun3), .frame_err(frame_err3)
  );

  always @(posedge clk) begin
    if (rx_valid0)    rxv0  <= rxv0 + 1;
    if (tx_underrun0) und0  <= und0 + 1;
    if (frame_err0)   ferr0 <= ferr0 + 1;
    if (rx_valid3)    rxv3  <= rxv3 + 1;
    if (tx_underrun3) und3  <= und3 + 1;
    if (frame_err3)   ferr3 <= ferr3 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int which, input logic [15:0] d);
    tx_data = d;
    if (which == 0) tx_valid0 = 1'b1; else tx_valid3 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
  endtask

  // Mode 0: MCU drives mosi on the falling edge, both sides sample on the rising edge.
  // lat = clk cycles from the last rising sclk edge to rx_valid (-1 when rx_valid never asserts).
  task automatic word0(input logic [15:0] mo, input int nbits, output logic [15:0] mi, output int lat);
    mi  = '0;
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[15-i];
      tick(HALF);
      mi[15-i] = miso0;
      sclk0 = 1'b1;
      for (int c = 1; c <= HALF; c++) begin
        @(negedge clk);
        if (rx_valid0 && lat < 0) lat = c;
      end
      sclk0 = 1'b0;
    end
  endtask

  task automatic frame0(input logic [15:0] mo, output logic [15:0] mi, output int lat);
    cs0 = 1'b0;
    tick(HALF);
    word0(mo, 16, mi, lat);
    tick(HALF);
    cs0 = 1'b1;
    tick(2 * HALF);
  endtask

  // Mode 3: leading edge falls (drive), trailing edge rises (sample).
  task automatic word3(input logic [15:0] mo, output logic [15:0] mi);
    mi = '0;
    for (int i = 0; i < 16; i++) begin
      sclk3 = 1'b0;
      mosi  = mo[15-i];
      tick(HALF);
      mi[15-i] = miso3;
      sclk3 = 1'b1;
      tick(HALF);
    end
  endtask

  initial begin
    logic [15:0] mi, mi_b;
    logic [15:0] wq [10];
    int lat, r0, u0, f0;

    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
           16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA};
    reset_n = 1'b0;
    sclk0 = 1'b0; cs0 = 1'b1; sclk3 = 1'b1; cs3 = 1'b1;
    mosi = 1'b0; tx_data = '0; tx_valid0 = 1'b0; tx_valid3 = 1'b0;
    tick(3);

    check("rst_tx_ready", tx_ready0, 1);
    check("rst_tx_count", tx_count0, 0);
    check("rst_miso", miso0, 0);
    check("rst_rx_data", rx_data0, 0);
    check("rst_flags", {rx_valid0, tx_underrun0, frame_err0}, 0);
    check("rst_miso_mode3", miso3, 0);
    reset_n = 1'b1;
    tick(6);

    // Mode 0 single frame with one queued word
    push(0, 16'hA5C3);
    check("push_count", tx_count0, 1);
    r0 = rxv0; u0 = und0;
    frame0(16'h1234, mi, lat);
    check("m0_miso", mi, 16'hA5C3);
    check("m0_rx_data", rx_data0, 16'h1234);
    check("m0_rx_valid_pulses", rxv0 - r0, 1);
    check("m0_rx_latency", lat, 4);
    check("m0_count_after", tx_count0, 0);
    check("m0_no_underrun", und0 - u0, 0);

    // Empty FIFO frame
    r0 = rxv0; u0 = und0;
    frame0(16'h5A5A, mi, lat);
    check("empty_miso", mi, 0);
    check("empty_underrun", und0 - u0, 1);
    check("empty_rx_data", rx_data0, 16'h5A5A);
    check("empty_rx_valid", rxv0 - r0, 1);

    // Aborted frame after 7 bits, then a clean frame
    push(0, 16'h1111);
    r0 = rxv0; f0 = ferr0;
    cs0 = 1'b0;
    tick(HALF);
    word0(16'hFFFF, 7, mi, lat);
    tick(HALF);
    cs0 = 1'b1;
    tick(2 * HALF);
    check("abort_frame_err", ferr0 - f0, 1);
    check("abort_no_rx_valid", rxv0 - r0, 0);
    check("abort_rx_held", rx_data0, 16'h5A5A);
    check("abort_partial_miso", mi, 16'h1000);
    check("abort_word_lost", tx_count0, 0);
    push(0, 16'h7E81);
    frame0(16'hC0DE, mi, lat);
    check("after_abort_miso", mi, 16'h7E81);
    check("after_abort_rx", rx_data0, 16'hC0DE);
    check("after_abort_no_err", ferr0 - f0, 1);

    // Overfill: 10 back-to-back pushes into 8 entries
    for (int k = 0; k < 10; k++) begin
      tx_data   = wq[k];
      tx_valid0 = 1'b1;
      @(negedge clk);
      check($sformatf("fill_ready%0d", k), tx_ready0, (k + 1 < 8) ? 1 : 0);
    end
    tx_valid0 = 1'b0;
    check("fill_count", tx_count0, 8);
    r0 = rxv0; u0 = und0;
    cs0 = 1'b0;
    tick(HALF);
    for (int k = 0; k < 9; k++) begin
      word0(~wq[k], 16, mi, lat);
      check($sformatf("fifo_word%0d", k), mi, (k < 8) ? wq[k] : 16'h0000);
    end
    tick(HALF);
    cs0 = 1'b1;
    tick(2 * HALF);
    check("drain_rx_valid", rxv0 - r0, 9);
    check("drain_underrun", und0 - u0, 1);
    check("drain_rx_data", rx_data0, 16'h6666);
    check("drain_count", tx_count0, 0);

    // Mode 3 two-word frame
    push(3, 16'h0001);
    push(3, 16'h8000);
    check("m3_count", tx_count3, 2);
    cs3 = 1'b0;
    tick(HALF);
    word3(16'hBEEF, mi);
    word3(16'hCAFE, mi_b);
    tick(HALF);
    cs3 = 1'b1;
    tick(2 * HALF);
    check("m3_miso_w0", mi, 16'h0001);
    check("m3_miso_w1", mi_b, 16'h8000);
    check("m3_rx_valid", rxv3, 2);
    check("m3_rx_data", rx_data3, 16'hCAFE);
    check("m3_flags", {und3[7:0], ferr3[7:0]}, 0);
    check("m3_count_after", tx_count3, 0);

    // Reset mid-frame at bit 9 with three words queued
    push(0, 16'hABCD);
    push(0, 16'hBCDE);
    push(0, 16'hCDEF);
    r0 = rxv0;
    cs0 = 1'b0;
    tick(HALF);
    word0(16'hFFFF, 9, mi, lat);
    reset_n = 1'b0;
    #1;
    check("midrst_miso", miso0, 0);
    check("midrst_count", tx_count0, 0);
    check("midrst_ready", tx_ready0, 1);
    check("midrst_rx_data", rx_data0, 0);
    tick(3);
    reset_n = 1'b1;
    tick(10);
    word0(16'h1234, 16, mi, lat);
    check("stale_cs_ignored_rx", rxv0 - r0, 0);
    check("stale_cs_ignored_miso", mi, 0);
    cs0 = 1'b1;
    tick(2 * HALF);
    u0 = und0;
    frame0(16'h0F0F, mi, lat);
    check("postrst_miso", mi, 0);
    check("postrst_rx_data", rx_data0, 16'h0F0F);
    check("postrst_rx_valid", rxv0 - r0, 1);
    check("postrst_underrun", und0 - u0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_target_fifo.md
SPI_TARGET_FIFO -- requirements
Module: spi_target_fifo

Interface
REQ-001 Parameter WORD_W, default 16: bits per SPI word, both RX and TX; legal range 8..32.
REQ-002 Parameter DEPTH, default 8: TX FIFO entries; power of two, 2..64.
REQ-003 Parameter CPOL, default 0: idle level of sclk.
REQ-004 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 clk  in  1  system clock; all state is clocked on its rising edge; clk SHALL be at least 8x the sclk frequency.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 sclk  in  1  SPI clock from the MCU, asynchronous to clk.
REQ-008 cs  in  1  chip select, active low, asynchronous.
REQ-009 mosi  in  1  serial data from the MCU, MSB first.
REQ-010 miso  out  1  serial data to the MCU, MSB first.
REQ-011 rx_data  out  WORD_W  last complete received word, e.g. an FFT sample.
REQ-012 rx_valid  out  1  one-clk pulse when rx_data updates.
REQ-013 tx_data  in  WORD_W  word to queue for the MCU, e.g. note or duration.
REQ-014 tx_valid  in  1  push request.
REQ-015 tx_ready  out  1  FIFO not full.
REQ-016 tx_count  out  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-017 tx_underrun  out  1  one-clk pulse when a word starts with the FIFO empty.
REQ-018 frame_err  out  1  one-clk pulse when cs deasserts mid-word.

Function
REQ-019 sclk, cs and mosi SHALL each pass through a 2-flop synchronizer, followed by one edge-detect register.
- Leading edge = sclk leaving the CPOL level; trailing edge = sclk returning to it.
REQ-020 FSM states SHALL be IDLE and SHIFT.
- IDLE -> SHIFT on synchronized cs falling.
- SHIFT -> IDLE on synchronized cs rising.
REQ-021 On entry to SHIFT, and at each word boundary in SHIFT (REQ-025), the block SHALL load a new word into the TX shift register.
- FIFO not empty: pop the head.
- FIFO empty: load all zeros and pulse tx_underrun.
REQ-022 miso SHALL equal the TX shift register MSB while in SHIFT, and 0 in IDLE.
REQ-023 Sample edge: shift the synchronized mosi into the RX shift register LSB and increment the bit counter.
REQ-024 Shift edge: shift the TX register left, filling with 0.
- CPHA=0: the shift edge is the trailing edge.
- CPHA=1: the shift edge is the leading edge, except the first leading edge of each word, which does not shift.
REQ-025 After the WORD_W-th sample edge of a word, on the next clk:
- rx_data <= the assembled word and rx_valid = 1 for exactly one cycle;
- the bit counter wraps to 0;
- the next TX word loads per REQ-021, replacing the pending shift.
- This is the word boundary; back-to-back words within one cs-low frame SHALL be supported.
REQ-026 Latency: rx_valid SHALL assert 4 clk cycles (+1 for metastability phase) after the physical sclk sample edge.
REQ-027 cs rising with bit counter != 0:
- discard the partial RX word; rx_data is held;
- pulse frame_err;
- clear the counter and TX register; the popped TX word is lost.
- cs rising with the counter at 0 SHALL not raise frame_err.
REQ-028 FIFO push occurs when tx_valid && tx_ready.
- tx_ready = !full, derived from registered occupancy.
- Push while full is ignored, including a same-cycle push and pop when full.
- Same-cycle push and pop when not full leaves tx_count unchanged.
REQ-029 FIFO read and write pointers SHALL wrap modulo DEPTH; tx_count SHALL never exceed DEPTH or underflow.
REQ-030 sclk edges seen in IDLE SHALL be ignored.

Reset
REQ-031 Asserting reset_n low SHALL immediately force all of the following, including mid-frame:
- state IDLE; miso 0; rx_data 0; rx_valid, tx_underrun and frame_err 0;
- tx_count 0, tx_ready 1, FIFO pointers 0;
- synchronizers set to cs = 1 and sclk = CPOL;
- FIFO contents are discarded.
REQ-032 After reset_n rises, the first frame SHALL start only on a fresh cs falling edge.

Verification
REQ-033 Mode 0, WORD_W=16: push 0xA5C3; send one frame with mosi 0x1234 -> miso 0xA5C3 MSB first, rx_data 0x1234, exactly one rx_valid, tx_count returns to 0.
REQ-034 Mode 3: push 0x0001 and 0x8000; send a 32-sclk frame with mosi 0xBEEF then 0xCAFE -> miso 0x0001 then 0x8000, two rx_valid pulses, rx_data ends at 0xCAFE.
REQ-035 Empty FIFO, one frame -> miso all 0, one tx_underrun pulse, rx_data still captured.
REQ-036 Push DEPTH+2 words back to back -> tx_ready low after DEPTH pushes, tx_count = DEPTH, last two words absent from output order.
REQ-037 cs rising after 7 bits -> frame_err pulse, no rx_valid, rx_data unchanged; the next full frame is received correctly.
REQ-038 reset_n low at bit 9 with 3 words queued -> miso 0, tx_count 0, tx_ready 1 immediately; no rx_valid until the next complete frame.
